control_serial_celdas: RTL and testbench

Bit-serial sequencer for the iterative cell network (celda_ini / celda_tipi / celda_final).
- Captures an N-bit word and reuses one instance of each cell over N clock cycles instead of building an N-cell combinational chain.
- Registers the inter-cell signals x, y, r between cycles.
- Returns the final-cell outputs I and Z with a busy/done handshake.
- Sits between the word source (register bank or test driver) and the result consumer.

---
 rtl/control_serial_pkg.sv | 20 ++
 rtl/celda_final.sv | 13 +
 rtl/celda_ini.sv | 12 +
 rtl/celda_tipi.sv | 15 +
 rtl/control_serial_fsm.sv | 78 +++++++
 rtl/control_serial_celdas.sv | 125 ++++++++++++
 tb/tb_control_serial_celdas.sv | 270 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/control_serial_pkg.sv
// Shared types for the bit-serial cell sequencer: FSM state encoding and sizing helpers.
// Pure declarations; no latency, no flow control.
package control_serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INI  = 3'd1,
        S_TIPI = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int N_MIN = 2;

    // Counter holds N-2 at most, so $clog2(N) bits suffice; never narrower than 1.
    function automatic int cnt_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/celda_final.sv
// Final cell of the iterative network: produces the word result I and Z.
// Combinational, zero latency, no flow control.
module celda_final (
    input  logic L,
    input  logic x,
    input  logic y,
    input  logic r,
    output logic I,
    output logic Z
);
    assign I = (r & ~y) | (y & ~r);
    assign Z = (x & L) | (r & ~L) | (y & ~r & L);
endmodule

// File: rtl/celda_ini.sv
// Initial cell of the iterative network: seeds x/y/r from the leading bit.
// Combinational, zero latency, no flow control.
module celda_ini (
    input  logic L,
    output logic X,
    output logic Y,
    output logic R
);
    assign X = L;
    assign Y = 1'b0;
    assign R = ~L;
endmodule

// File: rtl/celda_tipi.sv
// Typical (middle) cell of the iterative network: next x/y/r from current x/y/r and bit.
// Combinational, zero latency, no flow control.
module celda_tipi (
    input  logic L,
    input  logic x,
    input  logic y,
    input  logic r,
    output logic X,
    output logic Y,
    output logic R
);
    assign X = (~x & ~r & L) | (~x & ~y & L);
    assign Y = (x & ~y & ~r) | (~x & y & r);
    assign R = ~L;
endmodule

// File: rtl/control_serial_fsm.sv
// Sequencer state, bit counter and registered busy/done; N+1 cycles start-to-done, start ignored unless IDLE.
// Optional CONTROL_SERIAL_ABORT_EN adds i_abort, returning a busy run to IDLE without done.
module control_serial_fsm
    import control_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
`ifdef CONTROL_SERIAL_ABORT_EN
    input  logic   i_abort,
`endif
    output state_t o_state,
    output logic   o_busy,
    output logic   o_done
);
    localparam int CW = cnt_w(N);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
`ifdef CONTROL_SERIAL_ABORT_EN
            if (i_abort && r_busy) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_INI;
                        r_cnt   <= CW'(N - 2);
                        r_busy  <= 1'b1;
                    end
                end
                S_INI: begin
                    r_state <= (N > N_MIN) ? S_TIPI : S_FIN;
                end
                S_TIPI: begin
                    // One TIPI cycle per middle bit: counter runs N-2 down to 1.
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/control_serial_celdas.sv
// Bit-serial evaluation of the ini/tipi/final cell chain, one cell per clock; done N+1 cycles after start.
// start is ignored while busy or in DONE; optional CONTROL_SERIAL_ABORT_EN adds an abort input.
module control_serial_celdas
    import control_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef CONTROL_SERIAL_ABORT_EN
    input  logic         abort,
`endif
    input  logic [N-1:0] dato,
    output logic         busy,
    output logic         done,
    output logic         I_out,
    output logic         Z_out
);
    logic [N-1:0] r_sh;
    logic         r_x;
    logic         r_y;
    logic         r_r;
    logic         r_i;
    logic         r_z;

    state_t       w_state;
    logic         w_busy;
    logic         w_done;
    logic         w_l;
    logic         w_ini_x, w_ini_y, w_ini_r;
    logic         w_tipi_x, w_tipi_y, w_tipi_r;
    logic         w_fin_i, w_fin_z;

    control_serial_fsm #(.N(N)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
`ifdef CONTROL_SERIAL_ABORT_EN
        .i_abort (abort),
`endif
        .o_state (w_state),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    // The bit under evaluation is always the shift-register MSB.
    assign w_l = r_sh[N-1];

    celda_ini u_ini (
        .L (w_l),
        .X (w_ini_x),
        .Y (w_ini_y),
        .R (w_ini_r)
    );

    celda_tipi u_tipi (
        .L (w_l),
        .x (r_x),
        .y (r_y),
        .r (r_r),
        .X (w_tipi_x),
        .Y (w_tipi_y),
        .R (w_tipi_r)
    );

    celda_final u_final (
        .L (w_l),
        .x (r_x),
        .y (r_y),
        .r (r_r),
        .I (w_fin_i),
        .Z (w_fin_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
            r_x  <= 1'b0;
            r_y  <= 1'b0;
            r_r  <= 1'b0;
            r_i  <= 1'b0;
            r_z  <= 1'b0;
        end else begin
`ifdef CONTROL_SERIAL_ABORT_EN
            if (abort && w_busy) begin
                r_x <= 1'b0;
                r_y <= 1'b0;
                r_r <= 1'b0;
            end else
`endif
            case (w_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh <= dato;
                    end
                end
                S_INI: begin
                    r_x  <= w_ini_x;
                    r_y  <= w_ini_y;
                    r_r  <= w_ini_r;
                    r_sh <= r_sh << 1;
                end
                S_TIPI: begin
                    r_x  <= w_tipi_x;
                    r_y  <= w_tipi_y;
                    r_r  <= w_tipi_r;
                    r_sh <= r_sh << 1;
                end
                S_FIN: begin
                    r_i <= w_fin_i;
                    r_z <= w_fin_z;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign I_out = r_i;
    assign Z_out = r_z;

endmodule

// File: tb/tb_control_serial_celdas.sv
// Randomized scoreboard bench for three widths (N=2,3,8) of the serial cell sequencer.
module tb_control_serial_celdas;

    typedef struct {
        int         cyc;
        logic [1:0] iz;
    } exp_t;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] start_v;
`ifdef CONTROL_SERIAL_ABORT_EN
    logic [2:0] abort_v;
`endif
    logic [7:0] dato_a [3];
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] i_v;
    logic [2:0] z_v;

    exp_t q [3][$];
    int   acc   [3];
    int   freee [3];
    int   cyc;
    int   total;
    int   bad;
    int   to_cnt;
    logic finish_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NN = (g == 0) ? 2 : (g == 1) ? 3 : 8;
        control_serial_celdas #(.N(NN)) u_dut (
            .clk   (clk),
            .rst   (rst_v[g]),
            .start (start_v[g]),
`ifdef CONTROL_SERIAL_ABORT_EN
            .abort (abort_v[g]),
`endif
            .dato  (dato_a[g][NN-1:0]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .I_out (i_v[g]),
            .Z_out (z_v[g])
        );
    end

    function automatic int nof(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 8;
    endfunction

    // Walk the equivalent combinational chain, MSB first, returning {I, Z}.
    function automatic logic [1:0] model_iz(input logic [7:0] d, input int n);
        logic x, y, r, l, nx, ny;
        x = d[n-1];
        y = 1'b0;
        r = ~d[n-1];
        for (int b = n - 2; b >= 1; b--) begin
            l  = d[b];
            nx = (~x & ~r & l) | (~x & ~y & l);
            ny = (x & ~y & ~r) | (~x & y & r);
            r  = ~l;
            x  = nx;
            y  = ny;
        end
        l = d[0];
        return {r ^ y, (x & l) | (r & ~l) | (y & ~r & l)};
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s N=%0d cyc=%0d got=%0h want=%0h", nm, nof(i), cyc, got, want);
        end
    endtask

    // Reference model: a word is accepted when start is seen at or after the
    // instance's next free edge; its result appears N edges later.
    initial begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            acc[i]   = -1000;
            freee[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 3; i++) begin
                int n;
                n = nof(i);
                if (rst_v[i]) begin
                    q[i].delete();
                    acc[i]   = -1000;
                    freee[i] = cyc + 1;
                end
`ifdef CONTROL_SERIAL_ABORT_EN
                else if (abort_v[i] && cyc >= acc[i] + 1 && cyc <= acc[i] + n) begin
                    q[i].delete();
                    acc[i]   = -1000;
                    freee[i] = cyc + 1;
                end
`endif
                else if (start_v[i] && cyc >= freee[i]) begin
                    exp_t e;
                    e.cyc    = cyc + n;
                    e.iz     = model_iz(dato_a[i], n);
                    acc[i]   = cyc;
                    freee[i] = cyc + n + 2;
                    q[i].push_back(e);
                end
            end
        end
    end

    // Monitor: compares DUT outputs on every falling edge.
    initial begin
        logic [1:0] hold     [3];
        logic       rst_prev [3];
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            hold[i]     = 2'b00;
            rst_prev[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (finish_req) begin
                chk("wait_timeouts", 0, 32'(to_cnt), 32'd0);
                for (int i = 0; i < 3; i++) chk("pending_results", i, 32'(q[i].size()), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            for (int i = 0; i < 3; i++) begin
                int n;
                logic exp_busy;
                n = nof(i);
                if (rst_prev[i]) hold[i] = 2'b00;
                rst_prev[i] = rst_v[i];
                exp_busy = (cyc >= acc[i]) && (cyc <= acc[i] + n - 1);
                chk("busy", i, 32'(busy_v[i]), 32'(exp_busy));
                if (done_v[i]) begin
                    if (q[i].size() == 0) begin
                        chk("unexpected_done", i, 32'(done_v[i]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk("done_cycle", i, cyc, e.cyc);
                        chk("result_IZ", i, 32'({i_v[i], z_v[i]}), 32'(e.iz));
                        hold[i] = e.iz;
                    end
                end else begin
                    if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
                        chk("missing_done", i, 32'(done_v[i]), 32'd1);
                        void'(q[i].pop_front());
                    end
                    chk("held_IZ", i, 32'({i_v[i], z_v[i]}), 32'(hold[i]));
                end
            end
        end
    end

    task automatic issue(input int i, input logic [7:0] d);
        bit ok;
        dato_a[i]  = d;
        start_v[i] = 1'b1;
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (acc[i] == cyc) begin
                ok = 1;
                break;
            end
        end
        if (!ok) to_cnt++;
        start_v[i] = 1'b0;
        dato_a[i]  = 8'($urandom);
    endtask

    initial begin
        int         dir_i [6];
        logic [7:0] dir_d [6];
        dir_i = '{0, 0, 0, 1, 1, 2};
        dir_d = '{8'h03, 8'h00, 8'h02, 8'h06, 8'h05, 8'hFF};
        finish_req = 1'b0;
        to_cnt     = 0;
        rst_v      = 3'b111;
        start_v    = 3'b000;
`ifdef CONTROL_SERIAL_ABORT_EN
        abort_v    = 3'b000;
`endif
        for (int i = 0; i < 3; i++) dato_a[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst_v = 3'b000;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) issue(dir_i[k], dir_d[k]);
        repeat (12) @(posedge clk);
        #1;

        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 1) == 1);
                dato_a[i]  = 8'($urandom);
                rst_v[i]   = ($urandom_range(0, 79) == 0);
`ifdef CONTROL_SERIAL_ABORT_EN
                abort_v[i] = ($urandom_range(0, 19) == 0);
`endif
            end
            @(posedge clk);
            #1;
        end
        rst_v   = 3'b000;
        start_v = 3'b000;
`ifdef CONTROL_SERIAL_ABORT_EN
        abort_v = 3'b000;
`endif
        repeat (12) @(posedge clk);
        #1;

        // start held high with the word changing every cycle
        start_v = 3'b111;
        repeat (40) begin
            for (int i = 0; i < 3; i++) dato_a[i] = 8'($urandom);
            @(posedge clk);
            #1;
        end
        start_v = 3'b000;
        repeat (12) @(posedge clk);
        #1;

        // reset (and abort) landing in the third middle-cell cycle
        for (int i = 0; i < 3; i++) begin
            issue(i, 8'($urandom));
            repeat (nof(i) + 2) @(posedge clk);
            #1;
            issue(i, 8'($urandom));
            repeat (3) @(posedge clk);
            #1;
            rst_v[i] = 1'b1;
            @(posedge clk);
            #1;
            rst_v[i] = 1'b0;
`ifdef CONTROL_SERIAL_ABORT_EN
            issue(i, 8'($urandom));
            repeat (nof(i) + 2) @(posedge clk);
            #1;
            issue(i, 8'($urandom));
            repeat (3) @(posedge clk);
            #1;
            abort_v[i] = 1'b1;
            @(posedge clk);
            #1;
            abort_v[i] = 1'b0;
`endif
            repeat (12) @(posedge clk);
            #1;
        end

        repeat (20) @(posedge clk);
        #1;
        finish_req = 1'b1;
    end

endmodule
